// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: bus configuration record and response codes.
package axi4_lite_pkg;

   typedef struct packed {
      int unsigned A;            // address bits
      int unsigned N;            // data bytes
      bit          I;
      bit          USE_STRB;
      bit          USE_PROT;
      bit          USE_MOD_PORT;
   } axi4_lite_cfg_t;

   localparam axi4_lite_cfg_t AXI4_LITE_CFG_DEFAULT = '{
      A: 32, N: 4, I: 1'b1, USE_STRB: 1'b1, USE_PROT: 1'b0, USE_MOD_PORT: 1'b0
   };

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi4_lite_resp_t;

endpackage

// File: rtl/axi4_lite_hold_stage.sv
// One-entry valid/ready holding register; frees (or reloads) on take.
module axi4_lite_hold_stage #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         take,
   output logic         full,
   output logic [W-1:0] data
);

   assign in_ready = !full || take;

   // Load on handshake (wins over take so a same-edge beat reloads), else drain on take.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/axi4_lite_reg_responder.sv
// AXI4-Lite register responder: REGS word registers, strobed writes, B/R responses.
module axi4_lite_reg_responder
   import axi4_lite_pkg::*;
#(
   parameter axi4_lite_cfg_t CFG  = AXI4_LITE_CFG_DEFAULT,
   parameter int unsigned    REGS = 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [CFG.A-1:0]         awaddr,
   input  logic [2:0]               awprot,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [8*CFG.N-1:0]       wdata,
   input  logic [CFG.N-1:0]         wstrb,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   input  logic [CFG.A-1:0]         araddr,
   input  logic [2:0]               arprot,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [8*CFG.N-1:0]       rdata,
   output logic [1:0]               rresp,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [REGS*8*CFG.N-1:0]  reg_q,
   output logic [REGS-1:0]          reg_wr_pulse
);

   localparam int unsigned AW   = CFG.A;
   localparam int unsigned NB   = CFG.N;
   localparam int unsigned DW   = 8 * NB;
   localparam int unsigned OFF  = $clog2(NB);
   localparam int unsigned IDXW = AW - OFF;
   localparam int unsigned IW   = (REGS > 1) ? $clog2(REGS) : 1;

   logic                  aw_full, w_full, commit;
   logic [AW-1:0]         aw_addr_q;
   logic [DW-1:0]         w_data_q;
   logic [NB-1:0]         w_strb_q, strb_eff;
   logic [IDXW-1:0]       wr_idx_full, rd_idx_full;
   logic [IW-1:0]         wr_idx, rd_idx;
   logic                  wr_ok, rd_ok, ar_hs;
   logic [DW-1:0]         regs [REGS];
   axi4_lite_resp_t       bresp_q, rresp_q;
   logic                  unused_bits;

   axi4_lite_hold_stage #(.W(AW)) u_aw_stage (
      .clk      (aclk),
      .rst      (areset),
      .in_data  (awaddr),
      .in_valid (awvalid),
      .in_ready (awready),
      .take     (commit),
      .full     (aw_full),
      .data     (aw_addr_q)
   );

   axi4_lite_hold_stage #(.W(DW + NB)) u_w_stage (
      .clk      (aclk),
      .rst      (areset),
      .in_data  ({wstrb, wdata}),
      .in_valid (wvalid),
      .in_ready (wready),
      .take     (commit),
      .full     (w_full),
      .data     ({w_strb_q, w_data_q})
   );

   assign commit      = aw_full && w_full && (!bvalid || bready);
   assign strb_eff    = CFG.USE_STRB ? w_strb_q : '1;

   assign wr_idx_full = aw_addr_q[AW-1:OFF];
   assign wr_ok       = wr_idx_full < IDXW'(REGS);
   assign wr_idx      = wr_idx_full[IW-1:0];

   assign rd_idx_full = araddr[AW-1:OFF];
   assign rd_ok       = rd_idx_full < IDXW'(REGS);
   assign rd_idx      = rd_idx_full[IW-1:0];

   assign arready     = !rvalid || rready;
   assign ar_hs       = arvalid && arready;

   assign bresp       = bresp_q;
   assign rresp       = rresp_q;

   // Byte-lane offset bits and protection attributes carry no meaning here.
   assign unused_bits = ^{awprot, arprot, aw_addr_q[OFF-1:0], araddr[OFF-1:0]};

   // Register array: strobed byte-lane update and one-cycle pulse on an in-range commit.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int unsigned i = 0; i < REGS; i++) regs[i] <= '0;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (commit && wr_ok) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (strb_eff[b]) regs[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
            reg_wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   // Write response: raised on commit, held until accepted.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         bvalid  <= 1'b0;
         bresp_q <= OKAY;
      end else if (commit) begin
         bvalid  <= 1'b1;
         bresp_q <= wr_ok ? OKAY : SLVERR;
      end else if (bready) begin
         bvalid  <= 1'b0;
      end
   end

   // Read response: captured on AR handshake (pre-write register value), held until accepted.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rvalid  <= 1'b0;
         rresp_q <= OKAY;
         rdata   <= '0;
      end else if (ar_hs) begin
         rvalid  <= 1'b1;
         rresp_q <= rd_ok ? OKAY : SLVERR;
         rdata   <= rd_ok ? regs[rd_idx] : '0;
      end else if (rready) begin
         rvalid  <= 1'b0;
      end
   end

   // Flatten the register array onto the control-logic bus.
   always_comb begin
      reg_q = '0;
      for (int unsigned i = 0; i < REGS; i++) reg_q[i*DW +: DW] = regs[i];
   end

endmodule

// File: tb/tb_axi4_lite_reg_responder.sv
// Self-checking bench for axi4_lite_reg_responder with B/R scoreboards and a register model.
module tb_axi4_lite_reg_responder;
   import axi4_lite_pkg::*;

   localparam int unsigned REGS = 8;
   localparam int unsigned DW   = 32;

   logic                 aclk, areset;
   logic [31:0]          awaddr, araddr;
   logic [2:0]           awprot, arprot;
   logic                 awvalid, awready, wvalid, wready, bvalid, bready;
   logic                 arvalid, arready, rvalid, rready;
   logic [31:0]          wdata, rdata;
   logic [3:0]           wstrb;
   logic [1:0]           bresp, rresp;
   logic [REGS*DW-1:0]   reg_q;
   logic [REGS-1:0]      reg_wr_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]          resp;
      logic [REGS*DW-1:0]  regs;
   } b_exp_t;
   typedef struct {
      logic [1:0]          resp;
      logic [DW-1:0]       data;
   } r_exp_t;

   b_exp_t       b_q[$];
   r_exp_t       r_q[$];
   logic [DW-1:0] model [REGS];

   axi4_lite_reg_responder #(.CFG(AXI4_LITE_CFG_DEFAULT), .REGS(REGS)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [REGS*DW-1:0] model_flat();
      logic [REGS*DW-1:0] v;
      for (int i = 0; i < REGS; i++) v[i*DW +: DW] = model[i];
      return v;
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int unsigned idx;
      idx = addr >> 2;
      if (idx >= REGS) return 2'b10;
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      return 2'b00;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < REGS; i++) model[i] = '0;
   endfunction

   // Present AW and/or W; each drops independently after its own handshake.
   task automatic drive(input bit do_aw, input bit do_w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      bit aw_pend, w_pend, a_hs, w_hs;
      int c;
      aw_pend = do_aw; w_pend = do_w; c = 0;
      if (do_aw) begin awaddr = addr; awvalid = 1'b1; end
      if (do_w)  begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      while ((aw_pend || w_pend) && c < 50) begin
         @(negedge aclk);
         a_hs = aw_pend && awready;
         w_hs = w_pend && wready;
         @(posedge aclk); #1;
         if (a_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_hs) begin wvalid = 1'b0; w_pend = 1'b0; end
         c++;
      end
      checks++;
      if (aw_pend || w_pend) begin
         errors++;
         $display("FAIL write_handshake timeout: aw_pend=%0b w_pend=%0b required 0 0", aw_pend, w_pend);
         awvalid = 1'b0; wvalid = 1'b0;
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      b_exp_t e;
      e.resp = model_write(addr, data, strb);
      e.regs = model_flat();
      b_q.push_back(e);
      drive(1'b1, 1'b1, addr, data, strb);
   endtask

   task automatic collect_b(input int n, input int budget);
      int got;
      b_exp_t e;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge aclk);
         if (bvalid && bready) begin
            checks++;
            if (b_q.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected: bresp=%b with empty scoreboard", bresp);
            end else begin
               e = b_q.pop_front();
               if (bresp !== e.resp) begin
                  errors++;
                  $display("FAIL b_resp: got %b required %b", bresp, e.resp);
               end
               checks++;
               if (reg_q !== e.regs) begin
                  errors++;
                  $display("FAIL b_reg_q: got %h required %h", reg_q, e.regs);
               end
            end
            got++;
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL b_count: got %0d required %0d", got, n);
      end
      @(posedge aclk); #1;
   endtask

   task automatic collect_r(input int n, input int budget, output int first, output int last);
      int got;
      r_exp_t e;
      got = 0; first = -1; last = -1;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge aclk);
         if (rvalid && rready) begin
            if (first < 0) first = c;
            last = c;
            checks++;
            if (r_q.size() == 0) begin
               errors++;
               $display("FAIL r_unexpected: rdata=%h with empty scoreboard", rdata);
            end else begin
               e = r_q.pop_front();
               if (rresp !== e.resp || rdata !== e.data) begin
                  errors++;
                  $display("FAIL r_beat: got resp=%b data=%h required resp=%b data=%h",
                           rresp, rdata, e.resp, e.data);
               end
            end
            got++;
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL r_count: got %0d required %0d", got, n);
      end
      @(posedge aclk); #1;
   endtask

   task automatic do_read(input logic [31:0] addr);
      r_exp_t e;
      int unsigned idx;
      idx = addr >> 2;
      e.resp = (idx < REGS) ? 2'b00 : 2'b10;
      e.data = (idx < REGS) ? model[idx] : '0;
      r_q.push_back(e);
      araddr = addr; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL %s_readies: got %b required 111", tag, {awready, wready, arready});
      end
      checks++;
      if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
         errors++;
         $display("FAIL %s_valid_resp: got %b required 000000", tag, {bvalid, rvalid, bresp, rresp});
      end
      checks++;
      if (rdata !== '0 || reg_wr_pulse !== '0) begin
         errors++;
         $display("FAIL %s_rdata_pulse: got %h/%b required 0/0", tag, rdata, reg_wr_pulse);
      end
      checks++;
      if (reg_q !== '0) begin
         errors++;
         $display("FAIL %s_reg_q: got %h required 0", tag, reg_q);
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check_reset_values("reset");
      areset = 1'b0;
      @(posedge aclk); #1;
   endtask

   task automatic test_write_basic();
      b_exp_t e;
      e.resp = model_write(32'h04, 32'hDEADBEEF, 4'hF);
      e.regs = model_flat();
      b_q.push_back(e);
      drive(1'b1, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
      checks++;
      if (bvalid !== 1'b0) begin
         errors++;
         $display("FAIL wr_latency_early: bvalid=%b required 0", bvalid);
      end
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++;
         $display("FAIL wr_bvalid: got %b/%b required 1/00", bvalid, bresp);
      end
      checks++;
      if (reg_q[1*DW +: DW] !== 32'hDEADBEEF || reg_wr_pulse !== 8'b0000_0010) begin
         errors++;
         $display("FAIL wr_reg1_pulse: got %h/%b required deadbeef/00000010",
                  reg_q[1*DW +: DW], reg_wr_pulse);
      end
      collect_b(1, 10);
      checks++;
      if (reg_wr_pulse !== '0 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL wr_pulse_width: got pulse=%b bvalid=%b required 0 0", reg_wr_pulse, bvalid);
      end
   endtask

   task automatic test_w_first();
      b_exp_t e;
      do_write(32'h08, 32'hFFFFFFFF, 4'hF);
      collect_b(1, 20);
      e.resp = model_write(32'h08, 32'h1234ABCD, 4'h3);
      e.regs = model_flat();
      b_q.push_back(e);
      drive(1'b0, 1'b1, 32'h0, 32'h1234ABCD, 4'h3);
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL wfirst_hold: got wready=%b bvalid=%b required 0 0", wready, bvalid);
      end
      drive(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
      collect_b(1, 20);
      checks++;
      if (reg_q[2*DW +: DW] !== 32'hFFFFABCD) begin
         errors++;
         $display("FAIL wfirst_reg2: got %h required ffffabcd", reg_q[2*DW +: DW]);
      end
   endtask

   task automatic test_slverr();
      int f, l;
      do_write(32'h40, 32'h55AA55AA, 4'hF);
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b10 || reg_wr_pulse !== '0) begin
         errors++;
         $display("FAIL slverr_write: got bvalid=%b bresp=%b pulse=%b required 1 10 0",
                  bvalid, bresp, reg_wr_pulse);
      end
      collect_b(1, 10);
      do_read(32'h40);
      collect_r(1, 10, f, l);
   endtask

   task automatic test_b_stall();
      bready = 1'b0;
      fork
         begin
            do_write(32'h0C, 32'h11111111, 4'hF);
            do_write(32'h10, 32'h22222222, 4'hF);
            do_write(32'h14, 32'h33333333, 4'hF);
         end
         begin
            repeat (5) @(posedge aclk);
            #2;
            checks++;
            if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
               errors++;
               $display("FAIL stall_backpressure: got aw=%b w=%b bvalid=%b required 0 0 1",
                        awready, wready, bvalid);
            end
            bready = 1'b1;
         end
         collect_b(3, 60);
      join
   endtask

   task automatic test_back_to_back();
      int f, l;
      fork
         for (int i = 0; i < REGS; i++) do_write(i * 4, 32'hA5000000 + i * 32'h00010203, 4'hF);
         collect_b(REGS, 100);
      join
      fork
         begin
            arvalid = 1'b1;
            for (int i = 0; i < REGS; i++) begin
               r_exp_t e;
               araddr = i * 4;
               e.resp = 2'b00;
               e.data = model[i];
               r_q.push_back(e);
               @(posedge aclk); #1;
            end
            arvalid = 1'b0;
         end
         collect_r(REGS, 40, f, l);
      join
      checks++;
      if (l - f != REGS - 1) begin
         errors++;
         $display("FAIL rd_throughput: beat span %0d cycles required %0d", l - f, REGS - 1);
      end
   endtask

   task automatic test_rw_same();
      int f, l;
      r_exp_t e;
      e.resp = 2'b00;
      e.data = model[6];
      r_q.push_back(e);
      fork
         begin
            do_write(32'h18, 32'hCAFEF00D, 4'hF);
            araddr = 32'h18; arvalid = 1'b1;
            @(posedge aclk); #1;
            arvalid = 1'b0;
         end
         collect_b(1, 20);
         collect_r(1, 20, f, l);
      join
   endtask

   task automatic test_reset_mid();
      bit stray;
      bready = 1'b1; rready = 1'b0;
      awaddr = 32'h1C; awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      araddr = 32'h00; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_pre: got rvalid=%b bvalid=%b required 1 0", rvalid, bvalid);
      end
      #2 areset = 1'b1;
      #1;
      check_reset_values("midrst");
      model_clear();
      b_q.delete();
      r_q.delete();
      @(posedge aclk); #1;
      areset = 1'b0;
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      rready = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (bvalid || rvalid) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0 || reg_q !== '0) begin
         errors++;
         $display("FAIL midrst_no_resp: stray=%b reg_q=%h required 0 0", stray, reg_q);
      end
   endtask

   initial begin
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
      model_clear();
      test_reset();
      test_write_basic();
      test_w_first();
      test_slverr();
      test_b_stall();
      test_back_to_back();
      test_rw_same();
      test_reset_mid();
      checks++;
      if (b_q.size() != 0 || r_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: b=%0d r=%0d left, required 0 0", b_q.size(), r_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
